ber_checker: RTL and testbench
==============================

BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter SEED, default 9'h1AA: PRBS9 seed of the local reference generator; must match the transmit seed.
REQ-002 Parameter NB_CNT, default 64: width of the bit and error counters.
REQ-003 Parameter NB_WIN, default 9: width of the window counter; window length WIN = 2^NB_WIN - 1 = 511 valid bits.
REQ-004 Parameter THR, default 128: error count within one window above which lock is lost.
REQ-005 clock  in  1: system clock; single clock domain.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 i_enable  in  1: RX enable; when low, all state is held and i_valid is ignored.
REQ-008 i_valid  in  1: one-cycle strobe, one per decided symbol.
REQ-009 i_rx_bit  in  1: decided RX bit, qualified by i_valid.
REQ-010 o_bit_count  out  NB_CNT: bits compared while locked.
REQ-011 o_error_count  out  NB_CNT: mismatches while locked.
REQ-012 o_locked  out  1: high while in state LOCK.
REQ-013 o_delay  out  9: current alignment delay, range 0..510.

Function
REQ-014 Accepted sample = i_valid & i_enable & ~reset; only accepted samples change state.
REQ-015 Local PRBS9: polynomial x^9+x^5+1; 9-bit register loaded with SEED on reset; advances one step per accepted sample; its output bit is shifted into a 511-bit history register.
REQ-016 Reference bit = history[o_delay]; comparison uses the history value before that cycle's shift.
REQ-017 FSM has two states: SEARCH (reset state) and LOCK.
REQ-018 SEARCH: each accepted sample increments win_cnt and adds its mismatch to win_err (NB_WIN+1 bits wide, saturating).
REQ-019 SEARCH, at the accepted sample where win_cnt reaches WIN: if the total including that sample is 0, go to LOCK; otherwise o_delay advances by 1, wrapping 510 to 0. In both cases win_cnt and win_err clear.
REQ-020 LOCK: each accepted sample increments o_bit_count, and also o_error_count on mismatch; the window counters run as in SEARCH.
REQ-021 LOCK, at window end: if win_err > THR, go to SEARCH and advance o_delay by 1; otherwise stay in LOCK. o_bit_count and o_error_count are retained in both cases.
REQ-022 Both counters saturate at all-ones and never wrap.
REQ-023 Outputs are registered; counters and o_locked reflect an accepted sample on the next clock edge (1-cycle latency).
REQ-024 i_enable low mid-window: window progress is held and resumes when i_enable returns high; no clears.
REQ-025 i_valid asserted on consecutive cycles is legal; every such cycle is a separate sample.

Reset
REQ-026 reset high at a clock edge sets: FSM=SEARCH, PRBS=SEED, history=0, o_delay=0, win_cnt=0, win_err=0, o_bit_count=0, o_error_count=0, o_locked=0.
REQ-027 reset overrides any simultaneous i_valid and i_enable; a reset asserted mid-window or mid-LOCK discards all state.

Structure
REQ-028 PRBS9 polynomial taps, default SEED, and FSM state encodings live in a shared package, reused by the transmit PRBS.
REQ-029 The PRBS9 generator is one sub-module, prbs9_gen (seed parameter, enable, bit output); the same sub-module is used by the transmitter.
REQ-030 An I and a Q instance each feed their o_bit_count and o_error_count to the file register BER inputs.

Verification
REQ-031 Loopback from a prbs9_gen with the same seed at delay 0, continuous valid -> o_locked rises 1 cycle after the 511th valid, with o_delay=0, and o_error_count stays 0.
REQ-032 Stimulus delayed by 37 samples -> lock occurs after 38*511 valids with o_delay=37; 1000 further valids give o_bit_count=1000 and o_error_count=0.
REQ-033 While locked, one bit inverted -> o_error_count=1, o_locked stays 1.
REQ-034 While locked, all bits inverted for one window -> o_locked=0, o_delay increments, counters retain their values.
REQ-035 i_enable low for 100 cycles with valid toggling -> all outputs unchanged; reset pulse while locked -> all outputs 0 next cycle.
REQ-036 Counters forced to all-ones minus 1, then 3 mismatching samples -> both counters equal all-ones, with no wrap.

Source files
------------

// File: rtl/ber_checker_pkg.sv
// Shared PRBS9 definitions and checker FSM encoding, used by both the
// receive checker and the transmit pattern generator.
package ber_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } ber_state_e;

    localparam logic [8:0] PRBS9_SEED   = 9'h1AA;
    localparam int         PRBS9_TAP_HI = 8;   // x^9
    localparam int         PRBS9_TAP_LO = 4;   // x^5
    localparam int         PRBS9_LEN    = 511;

    function automatic logic prbs9_fb(input logic [8:0] s);
        return s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO];
    endfunction

endpackage

// File: rtl/ber_if.sv
// RX sample strobe and BER status bundle between the demodulator and checker.
interface ber_if #(
    parameter int NB_CNT = 64
);
    logic              i_enable;
    logic              i_valid;
    logic              i_rx_bit;
    logic [NB_CNT-1:0] o_bit_count;
    logic [NB_CNT-1:0] o_error_count;
    logic              o_locked;
    logic [8:0]        o_delay;

    modport master (
        output i_enable, i_valid, i_rx_bit,
        input  o_bit_count, o_error_count, o_locked, o_delay
    );

    modport slave (
        input  i_enable, i_valid, i_rx_bit,
        output o_bit_count, o_error_count, o_locked, o_delay
    );
endinterface

// File: rtl/prbs9_gen.sv
// PRBS9 (x^9+x^5+1) generator; o_bit is the bit shifted in on the next step.
module prbs9_gen
    import ber_checker_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic o_bit
);
    logic [8:0] state_q;

    assign o_bit = prbs9_fb(state_q);

    always_ff @(posedge clock) begin
        if (reset)       state_q <= SEED;
        else if (enable) state_q <= {state_q[7:0], o_bit};
    end
endmodule

// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: slides the reference alignment one bit per
// error-bearing window until a clean window is seen, then counts bits/errors.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter logic [8:0] SEED   = PRBS9_SEED,
    parameter int         NB_CNT = 64,
    parameter int         NB_WIN = 9,
    parameter int         THR    = 128
) (
    input logic  clock,
    input logic  reset,
    ber_if.slave bus
);
    localparam int WIN  = 2**NB_WIN - 1;
    localparam int HIST = PRBS9_LEN;

    ber_state_e        state_q, state_d;
    logic [8:0]        delay_q, delay_d, delay_inc;
    logic [HIST-1:0]   history_q;
    logic [NB_WIN-1:0] win_cnt_q;
    logic [NB_WIN:0]   win_err_q, win_err_sum;
    logic [NB_CNT-1:0] bit_cnt_q, err_cnt_q;
    logic              accept, prbs_bit, mismatch, win_end;

    assign accept = bus.i_valid & bus.i_enable;

    prbs9_gen #(.SEED(SEED)) u_prbs (
        .clock  (clock),
        .reset  (reset),
        .enable (accept),
        .o_bit  (prbs_bit)
    );

    // Reference is taken from history before this sample's shift.
    assign mismatch    = bus.i_rx_bit ^ history_q[delay_q];
    assign win_end     = accept && (win_cnt_q == NB_WIN'(WIN - 1));
    assign win_err_sum = (mismatch && win_err_q != '1) ? win_err_q + (NB_WIN+1)'(1) : win_err_q;
    assign delay_inc   = (delay_q == 9'(HIST - 1)) ? '0 : delay_q + 9'd1;

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        if (win_end) begin
            unique case (state_q)
                SEARCH: begin
                    if (win_err_sum == '0) state_d = LOCK;
                    else                   delay_d = delay_inc;
                end
                LOCK: begin
                    if (int'(win_err_sum) > THR) begin
                        state_d = SEARCH;
                        delay_d = delay_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SEARCH;
            delay_q   <= '0;
            history_q <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            if (accept) begin
                history_q <= {history_q[HIST-2:0], prbs_bit};
                win_cnt_q <= win_end ? '0 : win_cnt_q + NB_WIN'(1);
                win_err_q <= win_end ? '0 : win_err_sum;
                // The sample that completes the lock window is not counted.
                if (state_q == LOCK) begin
                    if (bit_cnt_q != '1)             bit_cnt_q <= bit_cnt_q + NB_CNT'(1);
                    if (mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + NB_CNT'(1);
                end
            end
        end
    end

    assign bus.o_bit_count   = bit_cnt_q;
    assign bus.o_error_count = err_cnt_q;
    assign bus.o_locked      = (state_q == LOCK);
    assign bus.o_delay       = delay_q;
endmodule

// File: tb/tb_ber_checker.sv
// Randomized-gap bench for ber_checker: two instances (64-bit counters/THR 128
// and 10-bit counters/THR 600) tracked cycle by cycle against a sequence model.
module tb_ber_checker;
    import ber_checker_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ber_if #(.NB_CNT(64)) bus_a ();
    ber_if #(.NB_CNT(10)) bus_b ();

    ber_checker #(.NB_CNT(64)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    ber_checker #(.NB_CNT(10), .THR(600)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    typedef struct {
        int          n;       // accepted samples since reset
        int          delay;
        bit          locked;
        int          wc;
        int          we;
        logic [63:0] bc;
        logic [63:0] ec;
        logic [63:0] cmax;
        int          thr;
    } mdl_t;

    mdl_t m [2];
    bit   xs [511];           // one period of the local PRBS9 output sequence
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference bit = local sequence bit produced 1+delay samples ago (0 before start).
    task automatic model_step(input int i, input bit rst, input bit acc, input bit rx);
        int k;
        bit refb, mis;
        if (rst) begin
            m[i].n = 0; m[i].delay = 0; m[i].locked = 0;
            m[i].wc = 0; m[i].we = 0; m[i].bc = '0; m[i].ec = '0;
        end else if (acc) begin
            k    = m[i].n - 1 - m[i].delay;
            refb = (k >= 0) ? xs[k % 511] : 1'b0;
            mis  = rx ^ refb;
            if (m[i].locked) begin
                if (m[i].bc != m[i].cmax) m[i].bc++;
                if (mis && m[i].ec != m[i].cmax) m[i].ec++;
            end
            m[i].wc++;
            if (mis && m[i].we < 1023) m[i].we++;
            if (m[i].wc == 511) begin
                if (!m[i].locked) begin
                    if (m[i].we == 0) m[i].locked = 1;
                    else              m[i].delay = (m[i].delay + 1) % 511;
                end else if (m[i].we > m[i].thr) begin
                    m[i].locked = 0;
                    m[i].delay  = (m[i].delay + 1) % 511;
                end
                m[i].wc = 0;
                m[i].we = 0;
            end
            m[i].n++;
        end
    endtask

    task automatic compare_all();
        check("a_locked", 64'(bus_a.o_locked),    64'(m[0].locked));
        check("a_delay",  64'(bus_a.o_delay),     64'(m[0].delay));
        check("a_bits",   bus_a.o_bit_count,      m[0].bc);
        check("a_errs",   bus_a.o_error_count,    m[0].ec);
        check("b_locked", 64'(bus_b.o_locked),    64'(m[1].locked));
        check("b_delay",  64'(bus_b.o_delay),     64'(m[1].delay));
        check("b_bits",   64'(bus_b.o_bit_count), m[1].bc);
        check("b_errs",   64'(bus_b.o_error_count), m[1].ec);
    endtask

    task automatic step(input bit rst, input bit en, input bit vld, input bit rx);
        reset = rst;
        bus_a.i_enable = en; bus_a.i_valid = vld; bus_a.i_rx_bit = rx;
        bus_b.i_enable = en; bus_b.i_valid = vld; bus_b.i_rx_bit = rx;
        @(posedge clock);
        model_step(0, rst, en & vld, rx);
        model_step(1, rst, en & vld, rx);
        #1;
        if (errors < 50) compare_all();
    endtask

    // Transmit stream aligned to reference delay d.
    function automatic bit stim(input int d);
        int t;
        t = m[0].n - 1 - d;
        return (t >= 0) ? xs[t % 511] : 1'b0;
    endfunction

    task automatic send(input int d, input bit inv);
        bit en;
        if ($urandom_range(0, 3) == 0) begin
            en = 1'($urandom_range(0, 1));
            step(1'b0, en, en ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b1, 1'b1, stim(d) ^ inv);
    endtask

    initial begin
        bit          q[$];
        logic [8:0]  seed;
        logic [63:0] sv_bc, sv_ec;

        seed = PRBS9_SEED;
        for (int b = 8; b >= 0; b--) q.push_back(seed[b]);
        for (int k = 0; k < 511; k++) begin
            q.push_back(q[k] ^ q[k+4]);   // x(k) = x(k-9) ^ x(k-5)
            xs[k] = q[k+9];
        end
        m[0].cmax = '1;       m[0].thr = 128;
        m[1].cmax = 64'd1023; m[1].thr = 600;

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_locked", 64'(bus_a.o_locked), 64'd0);
        check("rst_delay",  64'(bus_a.o_delay),  64'd0);
        check("rst_bits",   bus_a.o_bit_count,   64'd0);
        check("rst_errs",   bus_a.o_error_count, 64'd0);

        // Aligned loopback: lock right after the 511th valid.
        for (int i = 0; i < 510; i++) send(0, 1'b0);
        check("pre_lock", 64'(bus_a.o_locked), 64'd0);
        send(0, 1'b0);
        check("lock_d0",   64'(bus_a.o_locked), 64'd1);
        check("delay_d0",  64'(bus_a.o_delay),  64'd0);
        check("b_lock_d0", 64'(bus_b.o_locked), 64'd1);
        for (int i = 0; i < 100; i++) send(0, 1'b0);
        check("bits_100", bus_a.o_bit_count,   64'd100);
        check("errs_0",   bus_a.o_error_count, 64'd0);

        // Single inverted bit while locked.
        send(0, 1'b1);
        check("errs_1",     bus_a.o_error_count, 64'd1);
        check("lock_err1",  64'(bus_a.o_locked), 64'd1);

        // Enable low with toggling valid holds everything.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'(i % 2), 1'($urandom_range(0, 1)));
        check("hold_bits", bus_a.o_bit_count,   64'd101);
        check("hold_errs", bus_a.o_error_count, 64'd1);
        check("hold_lock", 64'(bus_a.o_locked), 64'd1);
        check("hold_dly",  64'(bus_a.o_delay),  64'd0);

        // One fully inverted window drops lock and slides delay.
        for (int i = 0; i < 600 && m[0].wc != 0; i++) send(0, 1'b0);
        sv_bc = m[0].bc;
        sv_ec = m[0].ec;
        for (int i = 0; i < 511; i++) send(0, 1'b1);
        check("unlock",       64'(bus_a.o_locked), 64'd0);
        check("unlock_delay", 64'(bus_a.o_delay),  64'd1);
        check("unlock_bits",  bus_a.o_bit_count,   sv_bc + 64'd511);
        check("unlock_errs",  bus_a.o_error_count, sv_ec + 64'd511);
        check("b_keep_lock",  64'(bus_b.o_locked), 64'd1);

        // Stream delayed by 37 samples.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 38*511 - 1; i++) send(37, 1'b0);
        check("pre_lock37", 64'(bus_a.o_locked), 64'd0);
        send(37, 1'b0);
        check("lock37",  64'(bus_a.o_locked), 64'd1);
        check("delay37", 64'(bus_a.o_delay),  64'd37);
        for (int i = 0; i < 1000; i++) send(37, 1'b0);
        check("bits_1000", bus_a.o_bit_count,   64'd1000);
        check("errs37_0",  bus_a.o_error_count, 64'd0);

        // Reset pulse while locked, with valid and enable high.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst2_locked", 64'(bus_a.o_locked), 64'd0);
        check("rst2_delay",  64'(bus_a.o_delay),  64'd0);
        check("rst2_bits",   bus_a.o_bit_count,   64'd0);
        check("rst2_errs",   bus_a.o_error_count, 64'd0);

        // Saturation on the 10-bit instance.
        for (int i = 0; i < 511; i++) send(0, 1'b0);
        check("b_lock_sat", 64'(bus_b.o_locked), 64'd1);
        for (int i = 0; i < 1022; i++) send(0, 1'b1);
        check("b_bits_m1", 64'(bus_b.o_bit_count),   64'd1022);
        check("b_errs_m1", 64'(bus_b.o_error_count), 64'd1022);
        for (int i = 0; i < 3; i++) send(0, 1'b1);
        check("b_bits_sat", 64'(bus_b.o_bit_count),   64'd1023);
        check("b_errs_sat", 64'(bus_b.o_error_count), 64'd1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
